// File: rtl/dac_interface_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_interface_if
//  Description : Write handshake and serial DAC bus bundled for dac_interface.
//                The slave side is the DAC controller; the master side is the
//                requester, which may also observe the serial bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dac_interface_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_channel;
  logic [11:0] wr_data;
  logic        wr_latch;
  logic        done;
  logic        DAC_CS_N;
  logic        DAC_SCK;
  logic        DAC_SDI;
  logic        DAC_LDAC_N;

  modport master (
    output wr_valid, wr_channel, wr_data, wr_latch,
    input  wr_ready, done, DAC_CS_N, DAC_SCK, DAC_SDI, DAC_LDAC_N
  );

  modport slave (
    input  wr_valid, wr_channel, wr_data, wr_latch,
    output wr_ready, done, DAC_CS_N, DAC_SCK, DAC_SDI, DAC_LDAC_N
  );
endinterface
`default_nettype wire

// File: rtl/dac_interface.sv
`default_nettype none
// ============================================================================
//  Module      : dac_interface
//  Description : Serialises one 16-bit frame {channel, mode, code} to an SPI
//                style DAC, MSB first, with optional LDAC pulse afterwards.
//                Every bus output comes straight from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_interface #(
  parameter int         CLK_DIV   = 25,     // clocks per SCK half-period, 2..255
  parameter logic [1:0] MODE_BITS = 2'b11   // frame bits [13:12]
) (
  input  logic           clock,
  input  logic           rst,
  dac_interface_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    LDAC  = 3'd5
  } state_t;

  // Terminal value of the half-period counter; every timed state ends on it.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q;
  logic [7:0]  div_q;
  logic [4:0]  bit_q;       // half-period index inside SHIFT, 0..31
  logic [15:0] shreg_q;     // frame, bit 15 already on SDI, shifts left
  logic        latch_q;
  logic        cs_n_q;
  logic        sck_q;
  logic        sdi_q;
  logic        ldac_n_q;
  logic        done_q;
  logic        ready_q;

  logic [15:0] frame_d;
  logic        div_end;

  // Frame as it would be captured on an accepting edge.
  assign frame_d = {bus.wr_channel, MODE_BITS, bus.wr_data};
  assign div_end = (div_q == DIV_LAST);

  // Transfer sequencer: state, counters and all registered bus outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= 8'd0;
      bit_q    <= 5'd0;
      shreg_q  <= 16'd0;
      latch_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      ldac_n_q <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q   <= 8'd0;
          bit_q   <= 5'd0;
          ready_q <= 1'b1;
          // ready_q (not the next value) gates acceptance, so the first
          // cycle after reset only raises ready.
          if (bus.wr_valid && ready_q) begin
            state_q <= SETUP;
            ready_q <= 1'b0;
            shreg_q <= frame_d;
            latch_q <= bus.wr_latch;
            cs_n_q  <= 1'b0;
            sdi_q   <= frame_d[15];
          end
        end
        SETUP: begin
          if (div_end) begin
            div_q   <= 8'd0;
            bit_q   <= 5'd0;
            sck_q   <= 1'b1;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_q <= 8'd0;
            if (bit_q == 5'd31) begin
              // Last low half done; SCK is already low.
              bit_q   <= 5'd0;
              state_q <= HOLD;
            end else begin
              bit_q <= bit_q + 5'd1;
              if (!bit_q[0]) begin
                // End of a high half: falling edge, advance data except
                // after the 16th bit, which is held until CS_N rises.
                sck_q <= 1'b0;
                if (bit_q != 5'd30) begin
                  sdi_q   <= shreg_q[14];
                  shreg_q <= {shreg_q[14:0], 1'b0};
                end
              end else begin
                sck_q <= 1'b1;
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        HOLD: begin
          if (div_end) begin
            div_q   <= 8'd0;
            cs_n_q  <= 1'b1;
            sdi_q   <= 1'b0;
            state_q <= GAP;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        GAP: begin
          if (div_end) begin
            div_q <= 8'd0;
            if (latch_q) begin
              ldac_n_q <= 1'b0;
              state_q  <= LDAC;
            end else begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        LDAC: begin
          if (div_end) begin
            div_q    <= 8'd0;
            ldac_n_q <= 1'b1;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready   = ready_q;
  assign bus.done       = done_q;
  assign bus.DAC_CS_N   = cs_n_q;
  assign bus.DAC_SCK    = sck_q;
  assign bus.DAC_SDI    = sdi_q;
  assign bus.DAC_LDAC_N = ldac_n_q;

endmodule
`default_nettype wire
